// File: rtl/ahb_resp_mux_pkg.sv
// Shared AHB definitions for the response multiplexer slice.
// Holds the bus-wide sizing constants (slave count, read-data width),
// the HTRANS encodings and the default-slave state enum. A helper
// function classifies an HTRANS value as an active (NONSEQ/SEQ) transfer.
package ahb_resp_mux_pkg;

    localparam int unsigned AHB_SLAVE_DEVICES = 4;
    localparam int unsigned AHB_DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    // NONSEQ and SEQ demand a response; IDLE and BUSY get zero-wait OKAY.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// AHB default slave: answers transfers to unmapped addresses.
// Active transfers get the two-cycle ERROR response, IDLE/BUSY get OKAY.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   hready        - HREADY seen by the bus (qualifies address phases)
//   unmapped      - current address phase targets no slave
//   htrans        - master HTRANS of the current address phase
//   ds_ready      - default slave HREADYOUT
//   ds_resp       - default slave HRESP
module ahb_default_slave
    import ahb_resp_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hready,
    input  logic       unmapped,
    input  logic [1:0] htrans,
    output logic       ds_ready,
    output logic       ds_resp
);

    ds_state_e state_q, state_d;
    logic      err_start;

    // An accepted address phase to an unmapped slave that needs a response.
    assign err_start = hready && unmapped && is_active(htrans);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
        unique case (state_q)
            DS_IDLE: begin
                if (err_start) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_ready = 1'b0;
                ds_resp  = 1'b1;
                state_d  = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp = 1'b1;
                // Final ERROR cycle doubles as the next address phase.
                if (hready) begin
                    state_d = err_start ? DS_ERR1 : DS_IDLE;
                end
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response multiplexer.
// Registers the decoder select during each accepted address phase and
// routes the selected slave's HREADYOUT/HRESP/HRDATA to the master during
// the data phase. Unmapped selects are served by the internal default slave.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   decoder_sel    - address-phase slave index (>= SLAVES means unmapped)
//   htrans         - master HTRANS
//   slaves_ready   - per-slave HREADYOUT
//   slaves_resp    - per-slave HRESP
//   slaves_rdata   - per-slave HRDATA
//   master_ready   - HREADY to master, also fed back to all slaves
//   master_resp    - HRESP to master
//   master_rdata   - HRDATA to master
module ahb_resp_mux
    import ahb_resp_mux_pkg::*;
#(
    parameter int unsigned SLAVES     = AHB_SLAVE_DEVICES,
    parameter int unsigned DATA_WIDTH = AHB_DATA_WIDTH,
    parameter int unsigned SELW       = $clog2(SLAVES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SELW-1:0]       decoder_sel,
    input  logic [1:0]            htrans,
    input  logic [SLAVES-1:0]     slaves_ready,
    input  logic [SLAVES-1:0]     slaves_resp,
    input  logic [DATA_WIDTH-1:0] slaves_rdata [SLAVES],
    output logic                  master_ready,
    output logic                  master_resp,
    output logic [DATA_WIDTH-1:0] master_rdata
);

    // Index value that selects the default slave.
    localparam logic [SELW-1:0] DEF_SEL = SELW'(SLAVES);

    logic [SELW-1:0] dsel_q;
    logic            unmapped_addr;
    logic            ds_ready;
    logic            ds_resp;

    assign unmapped_addr = (decoder_sel >= DEF_SEL);

    // Data-phase select only advances when the bus accepts an address phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsel_q <= DEF_SEL;
        end else if (master_ready) begin
            dsel_q <= decoder_sel;
        end
    end

    ahb_default_slave u_default_slave (
        .clk      (clk),
        .rst      (rst),
        .hready   (master_ready),
        .unmapped (unmapped_addr),
        .htrans   (htrans),
        .ds_ready (ds_ready),
        .ds_resp  (ds_resp)
    );

    always_comb begin
        master_ready = ds_ready;
        master_resp  = ds_resp;
        master_rdata = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (dsel_q == SELW'(i)) begin
                master_ready = slaves_ready[i];
                master_resp  = slaves_resp[i];
                master_rdata = slaves_rdata[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios followed by a
// randomized run, all checked against a transfer-level reference model.
module tb_ahb_resp_mux;
    import ahb_resp_mux_pkg::*;

    localparam int SL = AHB_SLAVE_DEVICES;
    localparam int DW = AHB_DATA_WIDTH;
    localparam int SW = $clog2(SL) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] decoder_sel;
    logic [1:0]    htrans;
    logic [SL-1:0] slaves_ready;
    logic [SL-1:0] slaves_resp;
    logic [DW-1:0] slaves_rdata [SL];
    logic          master_ready;
    logic          master_resp;
    logic [DW-1:0] master_rdata;

    int errors = 0;
    int checks = 0;

    // Reference model: which slave owns the current data phase, and how far
    // into an ERROR response (0 none, 1 first cycle, 2 second cycle) we are.
    int m_target;
    int m_err;

    ahb_resp_mux dut (
        .clk          (clk),
        .rst          (rst),
        .decoder_sel  (decoder_sel),
        .htrans       (htrans),
        .slaves_ready (slaves_ready),
        .slaves_resp  (slaves_resp),
        .slaves_rdata (slaves_rdata),
        .master_ready (master_ready),
        .master_resp  (master_resp),
        .master_rdata (master_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Check outputs mid-cycle against the model, then advance one edge.
    task automatic tick(input string tag);
        logic          er;
        logic          ep;
        logic [DW-1:0] ed;
        #2;
        if (m_target < SL) begin
            er = slaves_ready[m_target];
            ep = slaves_resp[m_target];
            ed = slaves_rdata[m_target];
        end else begin
            er = (m_err != 1);
            ep = (m_err != 0);
            ed = '0;
        end
        chk({tag, ".ready"}, DW'(master_ready), DW'(er));
        chk({tag, ".resp"},  DW'(master_resp),  DW'(ep));
        chk({tag, ".rdata"}, master_rdata, ed);
        @(posedge clk);
        if (rst) begin
            m_target = SL;
            m_err    = 0;
        end else if (er) begin
            m_target = int'(decoder_sel);
            m_err    = (m_target >= SL && htrans[1]) ? 1 : 0;
        end else if (m_err == 1) begin
            m_err = 2;
        end
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        decoder_sel  = '0;
        htrans       = HTRANS_IDLE;
        slaves_ready = '1;
        slaves_resp  = '0;
        for (int i = 0; i < SL; i++) slaves_rdata[i] = 32'h1000_0000 + i;

        // Reset held for two cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        m_target = SL;
        m_err    = 0;
        rst      = 1'b0;
        #1;
        chk("rst.ready", DW'(master_ready), DW'(1));
        chk("rst.resp",  DW'(master_resp),  DW'(0));
        chk("rst.rdata", master_rdata, '0);
        chk("rst.dsel",  DW'(dut.dsel_q), DW'(SL));

        // Mapped single read from slave 1.
        decoder_sel     = 3'd1;
        htrans          = HTRANS_NONSEQ;
        slaves_rdata[1] = 32'hA5A5_0001;
        tick("s1.addr");
        decoder_sel = 3'd0;
        htrans      = HTRANS_IDLE;
        #1;
        chk("s1.data", master_rdata, 32'hA5A5_0001);
        tick("s1.data");

        // Slave 0 inserts three wait states while the decoder moves to 2.
        decoder_sel = 3'd0;
        htrans      = HTRANS_NONSEQ;
        tick("s0.addr");
        slaves_ready[0] = 1'b0;
        decoder_sel     = 3'd2;
        slaves_rdata[0] = 32'h5A5A_0000;
        for (int i = 0; i < 3; i++) begin
            tick("s0.wait");
            chk("s0.dsel_hold", DW'(dut.dsel_q), DW'(0));
        end
        slaves_ready[0] = 1'b1;
        htrans          = HTRANS_IDLE;
        #1;
        chk("s0.data", master_rdata, 32'h5A5A_0000);
        tick("s0.done");

        // Unmapped NONSEQ: ERROR pair then OKAY.
        decoder_sel = 3'(SL);
        htrans      = HTRANS_NONSEQ;
        tick("um.addr");
        htrans = HTRANS_IDLE;
        tick("um.err1");
        tick("um.err2");
        tick("um.okay");
        // Unmapped IDLE: single zero-wait OKAY.
        tick("um.idle");
        chk("um.idle_state", DW'(dut.u_default_slave.state_q), DW'(DS_IDLE));

        // Back-to-back unmapped SEQ during the second ERROR cycle.
        htrans = HTRANS_NONSEQ;
        tick("b2b.addr");
        htrans = HTRANS_SEQ;
        tick("b2b.err1");
        tick("b2b.err2");
        chk("b2b.state", DW'(dut.u_default_slave.state_q), DW'(DS_ERR1));
        chk("b2b.ready", DW'(master_ready), DW'(0));
        chk("b2b.resp",  DW'(master_resp),  DW'(1));

        // Reset while in the first ERROR cycle aborts the transfer.
        rst = 1'b1;
        tick("rerr.rst");
        rst    = 1'b0;
        htrans = HTRANS_IDLE;
        #1;
        chk("rerr.ready", DW'(master_ready), DW'(1));
        chk("rerr.resp",  DW'(master_resp),  DW'(0));
        chk("rerr.state", DW'(dut.u_default_slave.state_q), DW'(DS_IDLE));
        tick("rerr.after");

        // Randomized traffic including unmapped selects and occasional reset.
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 49) == 0);
            decoder_sel = SW'($urandom_range(0, 6));
            htrans      = 2'($urandom_range(0, 3));
            for (int i = 0; i < SL; i++) begin
                slaves_ready[i] = ($urandom_range(0, 3) != 0);
                slaves_resp[i]  = ($urandom_range(0, 5) == 0);
                slaves_rdata[i] = $urandom;
            end
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter SLAVES, default `AHB_SLAVE_DEVICES, number of slave ports.
REQ-002 Parameter DATA_WIDTH, default `AHB_DATA_WIDTH, read-data width.
REQ-003 Parameter SELW, default $clog2(SLAVES)+1, decoder select width.
REQ-004 clk  in  1  sole clock; one clock, all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 decoder_sel  in  SELW  address-phase slave index; values >= SLAVES mean unmapped.
REQ-007 htrans  in  2  master HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 slaves_ready  in  SLAVES  per-slave HREADYOUT.
REQ-009 slaves_resp  in  SLAVES  per-slave HRESP (0 OKAY, 1 ERROR).
REQ-010 slaves_rdata  in  SLAVES x DATA_WIDTH  per-slave HRDATA, unpacked array.
REQ-011 master_ready  out  1  HREADY to master; also fed back to all slaves.
REQ-012 master_resp  out  1  HRESP to master.
REQ-013 master_rdata  out  DATA_WIDTH  HRDATA to master.

Function
REQ-014 Data-phase select register dsel SHALL load decoder_sel on every rising edge where master_ready=1; it SHALL hold otherwise.
REQ-015 When dsel < SLAVES, outputs SHALL combinationally equal slaves_ready[dsel], slaves_resp[dsel], slaves_rdata[dsel].
REQ-016 When dsel >= SLAVES, outputs SHALL come from the internal default slave; master_rdata SHALL be 0.
REQ-017 Default slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
REQ-018 DS_IDLE: ready=1, resp=0; on edge with master_ready=1, decoder_sel >= SLAVES and htrans[1]=1 -> DS_ERR1; else stay.
REQ-019 DS_ERR1: ready=0, resp=1; unconditionally -> DS_ERR2 next edge.
REQ-020 DS_ERR2: ready=1, resp=1; next edge re-evaluates REQ-018 condition -> DS_ERR1 or DS_IDLE.
REQ-021 Unmapped IDLE/BUSY transfers SHALL get zero-wait OKAY (FSM stays DS_IDLE).
REQ-022 Latency: selected-slave data phase adds zero cycles; unmapped NONSEQ/SEQ costs exactly two data-phase cycles.
REQ-023 Wait states: while master_ready=0, dsel and FSM SHALL not advance except DS_ERR1->DS_ERR2.
REQ-024 Back-to-back: address phase coinciding with DS_ERR2 or a slave's last ready=1 cycle SHALL be captured in that same edge.
REQ-025 decoder_sel changes while master_ready=0 SHALL be ignored.
REQ-026 Slave ERROR responses SHALL pass through unmodified, including their two-cycle shape.

Reset
REQ-027 On rst=1 at an edge: dsel <= SLAVES (default slave), FSM <= DS_IDLE.
REQ-028 Outputs after reset: master_ready=1, master_resp=0, master_rdata=0.
REQ-029 Reset mid-transfer (any FSM state, any dsel) SHALL abort it; outputs per REQ-028 from the next cycle.

Structure
REQ-030 htrans encodings and default-slave state enum SHALL live in the shared AHB package alongside definition.sv macros.
REQ-031 Default slave SHALL be a sub-module ahb_default_slave (FSM only); ahb_resp_mux instantiates it and the mux.
REQ-032 Port names SHALL match multip_if signal names so the block binds directly to that interface.

Verification
REQ-033 Reset: rst=1 two cycles -> master_ready=1, resp=0, rdata=0; dsel=SLAVES.
REQ-034 sel=1, NONSEQ, slave1 rdata=0xA5A5_0001 ready=1 -> next cycle master_rdata=0xA5A5_0001, ready=1, resp=0.
REQ-035 sel=0, slave0 ready=0 for 3 cycles, sel toggled to 2 meanwhile -> master_ready=0 three cycles, dsel stays 0, then slave0 data returned.
REQ-036 sel=SLAVES, NONSEQ -> ready=0/resp=1 then ready=1/resp=1; next cycle OKAY; sel=SLAVES with IDLE -> single OKAY cycle.
REQ-037 Back-to-back unmapped SEQ during DS_ERR2 -> FSM returns to DS_ERR1, ERROR pair repeated with no gap.
REQ-038 rst=1 asserted in DS_ERR1 -> next cycle ready=1, resp=0, FSM DS_IDLE.
